// File: rtl/bin_to_bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter with optional two's-complement sign handling.
// One shift per cycle; results are held between done pulses together with sign and overflow flags.
module bin_to_bcd_conv #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5,
    parameter bit SIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [BCD_W-1:0] scratch;
    logic [BCD_W-1:0] corrected;
    logic [BCD_W-1:0] shifted;
    logic             shift_out;
    logic [BIN_W-1:0] mag;
    logic [CNT_W-1:0] cnt;
    logic             sgn;
    logic             ovf;
    logic             last_iter;
    logic             in_neg;

    assign in_neg    = SIGNED && bin_in[BIN_W-1];
    assign last_iter = (cnt == CNT_W'(BIN_W - 1));
    assign busy      = (state == CONV);

    // Add-3 correction on every digit, then shift using the corrected digits in the same cycle.
    always_comb begin
        corrected = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] > 4'd4)
                corrected[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    assign {shift_out, shifted} = {corrected, mag[BIN_W-1]};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = CONV;
            CONV: if (last_iter) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scratch  <= '0;
            mag      <= '0;
            cnt      <= '0;
            sgn      <= 1'b0;
            ovf      <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            sign_out <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sgn     <= in_neg;
                        // Negating the most negative value yields 2^(BIN_W-1), correct as unsigned.
                        mag     <= in_neg ? (~bin_in + BIN_W'(1)) : bin_in;
                        scratch <= '0;
                        cnt     <= '0;
                        ovf     <= 1'b0;
                    end
                end
                CONV: begin
                    scratch <= shifted;
                    mag     <= {mag[BIN_W-2:0], 1'b0};
                    cnt     <= cnt + CNT_W'(1);
                    ovf     <= ovf | shift_out;
                    if (last_iter) begin
                        bcd_out  <= shifted;
                        sign_out <= sgn;
                        overflow <= ovf | shift_out;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_conv.sv
// Scoreboard bench for bin_to_bcd_conv: a signed 5-digit instance and an unsigned 4-digit instance,
// each checked against an arithmetic reference model through a queue of expected results.
module tb_bin_to_bcd_conv;

    typedef struct packed {
        logic [19:0] bcd;
        logic        sgn;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [15:0] bin0 = '0, bin1 = '0;
    logic        busy0, done0, sign0, ovf0;
    logic        busy1, done1, sign1, ovf1;
    logic [19:0] bcd0;
    logic [15:0] bcd1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bin_to_bcd_conv #(.BIN_W(16), .DIGITS(5), .SIGNED(1'b1)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .bin_in(bin0),
        .busy(busy0), .done(done0), .bcd_out(bcd0), .sign_out(sign0), .overflow(ovf0)
    );

    bin_to_bcd_conv #(.BIN_W(16), .DIGITS(4), .SIGNED(1'b0)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .bin_in(bin1),
        .busy(busy1), .done(done1), .bcd_out(bcd1), .sign_out(sign1), .overflow(ovf1)
    );

    // Reference: plain integer magnitude, decimal digits by repeated division.
    function automatic exp_t model(input logic [15:0] v, input bit sgnd, input int digits);
        exp_t   e;
        longint m, p10;
        e.sgn = sgnd && v[15];
        m     = e.sgn ? (65536 - longint'(v)) : longint'(v);
        p10   = 1;
        for (int i = 0; i < digits; i++) p10 = p10 * 10;
        e.ovf = (m >= p10);
        m     = m % p10;
        e.bcd = '0;
        for (int i = 0; i < digits; i++) begin
            e.bcd[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done0) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_bad++;
                $display("FAIL dut0_unexpected_done: got bcd 0x%05h with no conversion pending", bcd0);
            end else begin
                e = q0.pop_front();
                if (bcd0 !== e.bcd || sign0 !== e.sgn || ovf0 !== e.ovf) begin
                    n_bad++;
                    $display("FAIL dut0_result: got bcd=0x%05h sign=%0b ovf=%0b expected bcd=0x%05h sign=%0b ovf=%0b",
                             bcd0, sign0, ovf0, e.bcd, e.sgn, e.ovf);
                end
            end
        end
        if (done1) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_bad++;
                $display("FAIL dut1_unexpected_done: got bcd 0x%04h with no conversion pending", bcd1);
            end else begin
                e = q1.pop_front();
                if ({4'h0, bcd1} !== e.bcd || sign1 !== e.sgn || ovf1 !== e.ovf) begin
                    n_bad++;
                    $display("FAIL dut1_result: got bcd=0x%04h sign=%0b ovf=%0b expected bcd=0x%05h sign=%0b ovf=%0b",
                             bcd1, sign1, ovf1, e.bcd, e.sgn, e.ovf);
                end
            end
        end
    end

    // Drive start for one cycle; returns just after the accepting edge.
    task automatic issue0(input logic [15:0] v, input bit expect_result);
        start0 = 1'b1;
        bin0   = v;
        if (expect_result) q0.push_back(model(v, 1'b1, 5));
        @(posedge clk); #1;
        start0 = 1'b0;
    endtask

    task automatic issue1(input logic [15:0] v);
        start1 = 1'b1;
        bin1   = v;
        q1.push_back(model(v, 1'b0, 4));
        @(posedge clk); #1;
        start1 = 1'b0;
    endtask

    // Count edges until done is seen; returns 0 on timeout.
    task automatic wait_done0(output int k);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done0) begin k = i; break; end
        end
        if (k == 0) chk("dut0_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done1();
        int k;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done1) begin k = i; break; end
        end
        if (k == 0) chk("dut1_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int k;
        logic [15:0] v;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("reset_busy",     {31'd0, busy0}, 32'd0);
        chk("reset_done",     {31'd0, done0}, 32'd0);
        chk("reset_bcd",      {12'd0, bcd0},  32'd0);
        chk("reset_sign_ovf", {30'd0, sign0, ovf0}, 32'd0);

        issue0(16'h0000, 1'b1);
        chk("busy_after_accept", {31'd0, busy0}, 32'd1);
        wait_done0(k);
        chk("latency_edges", k, 32'd16);
        chk("busy_clear_at_done", {31'd0, busy0}, 32'd0);

        issue0(16'd12345, 1'b1); wait_done0(k);
        issue0(16'hFFFF, 1'b1);  wait_done0(k);
        issue0(16'h8000, 1'b1);  wait_done0(k);
        chk("most_negative_bcd", {12'd0, bcd0}, 32'h32768);
        issue0(16'h7FFF, 1'b1);  wait_done0(k);
        chk("most_positive_bcd", {12'd0, bcd0}, 32'h32767);

        // Start pulse while busy is ignored.
        issue0(16'h7FFF, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        start0 = 1'b1; bin0 = 16'h0001;
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_done0(k);
        chk("ignored_start_latency", k, 32'd12);
        // Back-to-back: start in the done cycle.
        issue0(16'h0064, 1'b1);
        wait_done0(k);
        chk("back_to_back_latency", k + 1, 32'd17);
        chk("back_to_back_bcd", {12'd0, bcd0}, 32'h00100);

        // Reset aborts a conversion in flight.
        issue0(16'h002A, 1'b1); wait_done0(k);
        chk("pre_abort_bcd", {12'd0, bcd0}, 32'h00042);
        issue0(16'h1234, 1'b0);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_bcd",  {12'd0, bcd0},  32'd0);
        chk("abort_sign", {31'd0, sign0}, 32'd0);
        k = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done0) k++;
        end
        chk("abort_no_done", k, 32'd0);

        for (int i = 0; i < 40; i++) begin
            v = 16'($urandom);
            if (i % 8 == 0) v = 16'($urandom_range(0, 9));
            issue0(v, 1'b1);
            wait_done0(k);
        end

        // Unsigned 4-digit instance: overflow wraps modulo 10^4.
        issue1(16'hFFFF); wait_done1();
        chk("u4_overflow_flag", {31'd0, ovf1}, 32'd1);
        chk("u4_overflow_bcd",  {16'd0, bcd1}, 32'h5535);
        issue1(16'd9999); wait_done1();
        chk("u4_max_fit", {15'd0, ovf1, bcd1}, 32'h09999);
        for (int i = 0; i < 30; i++) begin
            issue1(16'($urandom));
            wait_done1();
        end

        repeat (3) @(posedge clk);
        chk("dut0_queue_drained", q0.size(), 32'd0);
        chk("dut1_queue_drained", q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
